piso_stream_serializer: RTL and testbench

Parametrised parallel-in/serial-out serializer. It is the next generation of the team's basic 8-bit load/shift serializer. It adds configurable width, MSB/LSB-first order, a per-bit clock divider, a valid/ready input handshake and a one-word holding buffer, so back-to-back words stream with no idle gap. It sits between a parallel word producer and a single-wire serial link, and emits framing strobes for the downstream deserializer.

---
 rtl/piso_stream_serializer.sv | 127 ++++++++++++
 tb/tb_piso_stream_serializer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/piso_stream_serializer.sv
// Parallel-in / serial-out stream serializer.
// A word passes through a one-word holding buffer on a valid/ready handshake, then into a
// shift register. Each bit is held for BIT_DIV cycles. When a word is already waiting in
// the buffer, it is loaded on the same edge that the previous word's last bit ends, so
// back-to-back words stream with no idle cycle.
// Framing strobes mark the first and last bit of every word for the downstream deserializer.
module piso_stream_serializer #(
   parameter int WIDTH     = 8,
   parameter int LSB_FIRST = 0,
   parameter int BIT_DIV   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] par_data,
   input  logic             load,
   output logic             ready,
   output logic             ser_o,
   output logic             ser_valid,
   output logic             ser_first,
   output logic             ser_last,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);

   typedef enum logic {S_IDLE, S_SHIFT} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   hold_q, hold_d;
   logic               hold_full_q, hold_full_d;
   logic [WIDTH-1:0]   shift_q, shift_d;
   logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic               ser_o_q, ser_valid_q, ser_first_q, ser_last_q, busy_q;
   logic               take_word;
   logic               head_bit_d;

   // Next-state logic: handshake capture, divider/bit sequencing and word hand-over.
   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      div_d       = div_q;
      take_word   = 1'b0;

      // Accept only into an empty buffer, so a transfer out of it can never collide.
      if (load && !hold_full_q) begin
         hold_d      = par_data;
         hold_full_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (hold_full_q) take_word = 1'b1;
         end
         S_SHIFT: begin
            if (div_q == DIV_LAST) begin
               div_d = '0;
               if (bit_cnt_q == LAST_BIT) begin
                  // The last bit is done. Chain straight into the buffered word if one is waiting.
                  if (hold_full_q) take_word = 1'b1;
                  else             state_d   = S_IDLE;
               end else begin
                  if (LSB_FIRST != 0) shift_d = {1'b0, shift_q[WIDTH-1:1]};
                  else                shift_d = {shift_q[WIDTH-2:0], 1'b0};
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (take_word) begin
         shift_d     = hold_q;
         hold_full_d = 1'b0;
         bit_cnt_d   = '0;
         div_d       = '0;
         state_d     = S_SHIFT;
      end

      head_bit_d = (LSB_FIRST != 0) ? shift_d[0] : shift_d[WIDTH-1];
   end

   // State registers, plus outputs registered from next state so nothing depends on load or par_data combinationally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         div_q       <= '0;
         ser_o_q     <= 1'b0;
         ser_valid_q <= 1'b0;
         ser_first_q <= 1'b0;
         ser_last_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         div_q       <= div_d;
         ser_o_q     <= (state_d == S_SHIFT) && head_bit_d;
         ser_valid_q <= (state_d == S_SHIFT);
         ser_first_q <= (state_d == S_SHIFT) && (bit_cnt_d == '0);
         ser_last_q  <= (state_d == S_SHIFT) && (bit_cnt_d == LAST_BIT);
         busy_q      <= (state_d == S_SHIFT) || hold_full_d;
      end
   end

   assign ready     = ~hold_full_q;
   assign ser_o     = ser_o_q;
   assign ser_valid = ser_valid_q;
   assign ser_first = ser_first_q;
   assign ser_last  = ser_last_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_piso_stream_serializer.sv
// Self-checking bench for piso_stream_serializer.
// Three instances run side by side: default (8-bit, MSB first), 8-bit LSB first, and
// 4-bit with BIT_DIV=3.
// The reference model works at stream level. Each accepted word is expanded into its list
// of per-cycle output symbols, and the model plays that list back one symbol per cycle.
module tb_piso_stream_serializer;

   logic       clk;
   logic       rst;
   logic [2:0] load;
   logic [7:0] data [3];
   logic [2:0] ready, ser_o, ser_valid, ser_first, ser_last, busy;

   piso_stream_serializer #(.WIDTH(8), .LSB_FIRST(0), .BIT_DIV(1)) u_msb (
      .clk(clk), .rst(rst), .par_data(data[0]), .load(load[0]), .ready(ready[0]),
      .ser_o(ser_o[0]), .ser_valid(ser_valid[0]), .ser_first(ser_first[0]),
      .ser_last(ser_last[0]), .busy(busy[0]));

   piso_stream_serializer #(.WIDTH(8), .LSB_FIRST(1), .BIT_DIV(1)) u_lsb (
      .clk(clk), .rst(rst), .par_data(data[1]), .load(load[1]), .ready(ready[1]),
      .ser_o(ser_o[1]), .ser_valid(ser_valid[1]), .ser_first(ser_first[1]),
      .ser_last(ser_last[1]), .busy(busy[1]));

   piso_stream_serializer #(.WIDTH(4), .LSB_FIRST(0), .BIT_DIV(3)) u_div (
      .clk(clk), .rst(rst), .par_data(data[2][3:0]), .load(load[2]), .ready(ready[2]),
      .ser_o(ser_o[2]), .ser_valid(ser_valid[2]), .ser_first(ser_first[2]),
      .ser_last(ser_last[2]), .busy(busy[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Per-instance configuration and reference model state.
   int         cfg_w [3] = '{8, 8, 4};
   int         cfg_d [3] = '{1, 1, 3};
   int         cfg_l [3] = '{0, 1, 0};
   logic [7:0] m_hold [3];
   logic       m_hold_v [3];
   logic [2:0] m_fifo [3][64];   // {bit, first, last} per output cycle
   int         m_head [3];
   int         m_cnt [3];

   int          n_checks = 0;
   int          n_pass   = 0;
   int          cyc      = 0;
   logic [15:0] cap [3];
   int          valid_cnt0, first_cnt0;

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_hold_v[i] = 1'b0;
         m_hold[i]   = '0;
         m_head[i]   = 0;
         m_cnt[i]    = 0;
      end
   endtask

   task automatic model_expand(input int i, input logic [7:0] w);
      logic b;
      for (int k = 0; k < cfg_w[i]; k++) begin
         b = (cfg_l[i] != 0) ? w[k] : w[cfg_w[i]-1-k];
         for (int d = 0; d < cfg_d[i]; d++) begin
            m_fifo[i][(m_head[i] + m_cnt[i]) % 64] = {b, (k == 0), (k == cfg_w[i]-1)};
            m_cnt[i]++;
         end
      end
   endtask

   // One rising edge of the model: retire the symbol just shown, hand the buffer over, accept.
   task automatic model_edge();
      logic old_v;
      if (!rst) begin
         model_reset();
         return;
      end
      for (int i = 0; i < 3; i++) begin
         old_v = m_hold_v[i];
         if (m_cnt[i] > 0) begin
            m_head[i] = (m_head[i] + 1) % 64;
            m_cnt[i]--;
         end
         if (old_v && m_cnt[i] == 0) begin
            model_expand(i, m_hold[i]);
            m_hold_v[i] = 1'b0;
         end
         if (!old_v && load[i]) begin
            m_hold[i]   = data[i] & 8'((1 << cfg_w[i]) - 1);
            m_hold_v[i] = 1'b1;
            $display("cyc=%0d inst%0d accept word=%h", cyc, i, m_hold[i]);
         end
      end
   endtask

   task automatic check_all(input string tag);
      logic [5:0] obs, exp;
      logic [2:0] sym;
      for (int i = 0; i < 3; i++) begin
         sym = (m_cnt[i] > 0) ? m_fifo[i][m_head[i]] : 3'b000;
         exp = {!m_hold_v[i], sym[2], (m_cnt[i] > 0), sym[1], sym[0],
                (m_cnt[i] > 0) || m_hold_v[i]};
         obs = {ready[i], ser_o[i], ser_valid[i], ser_first[i], ser_last[i], busy[i]};
         n_checks++;
         assert (obs === exp) n_pass++;
         else $error("FAIL %s inst%0d cyc=%0d {rdy,ser,vld,fst,lst,busy} observed=%b expected=%b",
                     tag, i, cyc, obs, exp);
      end
   endtask

   task automatic check_val(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      cyc++;
      model_edge();
      #1;
      check_all(tag);
      for (int i = 0; i < 3; i++)
         if (ser_valid[i] === 1'b1) cap[i] = {cap[i][14:0], ser_o[i]};
      if (ser_valid[0] === 1'b1) valid_cnt0++;
      if (ser_first[0] === 1'b1) first_cnt0++;
   endtask

   task automatic clear_caps();
      for (int i = 0; i < 3; i++) cap[i] = '0;
      valid_cnt0 = 0;
      first_cnt0 = 0;
   endtask

   initial begin
      rst  = 1'b0;
      load = '0;
      for (int i = 0; i < 3; i++) data[i] = '0;
      model_reset();
      clear_caps();
      #1;
      check_all("reset_state");
      step("reset_hold");
      step("reset_hold");
      rst = 1'b1;
      step("idle");

      // Single word on every instance: A6 (8-bit) and 1001 (4-bit, BIT_DIV=3).
      clear_caps();
      load = 3'b111; data[0] = 8'hA6; data[1] = 8'hA6; data[2] = 8'h09;
      step("single_accept");
      load = '0;
      for (int n = 0; n < 15; n++) step("single_run");
      check_val("single_msb_word", int'(cap[0]), 16'h00A6);
      check_val("single_lsb_order", int'(cap[1]), 16'h0065);
      check_val("div3_pattern", int'(cap[2]), 16'h0E07);

      // Back-to-back words on the default instance, with load held high.
      clear_caps();
      load = 3'b001; data[0] = 8'hA6;
      step("b2b_accept1");
      data[0] = 8'h3C;
      step("b2b_transfer");
      step("b2b_accept2");
      load = '0;
      for (int n = 0; n < 20; n++) step("b2b_run");
      check_val("b2b_stream", int'(cap[0]), 16'hA63C);
      check_val("b2b_valid_cycles", valid_cnt0, 16);
      check_val("b2b_first_strobes", first_cnt0, 2);

      // Backpressure: load held high, data changing every cycle.
      load = 3'b111;
      for (int n = 0; n < 60; n++) begin
         for (int i = 0; i < 3; i++) data[i] = 8'($urandom_range(0, 255));
         step("backpressure");
      end

      // Random load and data.
      for (int n = 0; n < 300; n++) begin
         for (int i = 0; i < 3; i++) data[i] = 8'($urandom_range(0, 255));
         load = 3'($urandom_range(0, 7));
         step("random");
      end
      load = '0;
      for (int n = 0; n < 40; n++) step("drain");

      // Reset during bit 3 of a word, with a second word buffered.
      load = 3'b111; data[0] = 8'hC5; data[1] = 8'h5A; data[2] = 8'h0B;
      step("rstmid_accept");
      load = '0;
      step("rstmid_transfer");
      load = 3'b111; data[0] = 8'h81; data[1] = 8'hE7; data[2] = 8'h06;
      step("rstmid_buffer");
      load = '0;
      step("rstmid_bit2");
      step("rstmid_bit3");
      rst = 1'b0;
      #1;
      model_reset();
      check_all("rstmid_async");
      step("rstmid_hold");
      step("rstmid_hold");
      rst = 1'b1;
      clear_caps();
      for (int n = 0; n < 16; n++) step("rstmid_after");
      check_val("rstmid_no_stale", valid_cnt0, 0);

      // Resume normally after the reset.
      load = 3'b111; data[0] = 8'h5D; data[1] = 8'h5D; data[2] = 8'h0C;
      step("resume_accept");
      load = '0;
      for (int n = 0; n < 16; n++) step("resume_run");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
